// File: rtl/dvsdclaa_pipe_pkg.sv
// dvsdclaa_pipe_pkg
//   Shared defaults and small helpers for the pipelined CLA add/subtract unit.
//   DEF_WIDTH / DEF_GRP : default operand width and lookahead-group size.
//   num_groups()        : number of pipeline stages for a given width/group.
package dvsdclaa_pipe_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GRP   = 4;

  function automatic int num_groups(input int width, input int grp);
    return width / grp;
  endfunction

endpackage

// File: rtl/dvsdclaa_grp.sv
// dvsdclaa_grp
//   Combinational GRP-bit carry-lookahead adder slice. Every internal carry is
//   a flat sum of products of generate/propagate terms and the group carry-in,
//   so no carry ripples through the slice.
//   Ports:
//     a, b     in  GRP  operand bits of this group (b already inverted for sub)
//     c        in  1    carry into the group
//     s        out GRP  sum bits
//     grp_p    out 1    group propagate
//     grp_g    out 1    group generate (carry out assuming c = 0)
//     cout     out 1    carry out of the group MSB
//     msb_cin  out 1    carry into the group MSB (for signed overflow)
module dvsdclaa_grp
  import dvsdclaa_pipe_pkg::*;
#(
  parameter int GRP = DEF_GRP
) (
  input  logic [GRP-1:0] a,
  input  logic [GRP-1:0] b,
  input  logic           c,
  output logic [GRP-1:0] s,
  output logic           grp_p,
  output logic           grp_g,
  output logic           cout,
  output logic           msb_cin
);

  logic [GRP-1:0] p;
  logic [GRP-1:0] g;
  logic [GRP-1:0] car;
  logic [GRP-1:0] ci;

  always_comb begin : lookahead
    logic pp;
    p     = a ^ b;
    g     = a & b;
    car   = '0;
    ci    = '0;
    pp    = 1'b0;
    grp_g = 1'b0;
    // car[i] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c
    for (int i = 0; i < GRP; i++) begin
      car[i] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        car[i] = car[i] | (pp & g[j]);
        pp     = pp & p[j];
      end
      if (i == GRP - 1) begin
        grp_g = car[i];
      end
      car[i] = car[i] | (pp & c);
    end
    ci[0] = c;
    for (int i = 1; i < GRP; i++) begin
      ci[i] = car[i-1];
    end
    s       = p ^ ci;
    grp_p   = &p;
    cout    = car[GRP-1];
    msb_cin = ci[GRP-1];
  end

endmodule

// File: rtl/dvsdclaa_pipe.sv
// dvsdclaa_pipe
//   Pipelined carry-lookahead add/subtract unit. A WIDTH-bit operation is split
//   into NGRP = WIDTH/GRP groups, one group resolved per stage; the inter-group
//   carry is registered, so cycle time is that of one GRP-bit CLA.
//   Latency NGRP cycles, throughput one beat per cycle, valid/ready at both ends.
//   Ports:
//     clk, rst             clock (rising edge), async active-high reset
//     in_valid / in_ready  operand handshake
//     a, b, cin, sub       operands; sub=1 computes a-b (cin ignored)
//     out_valid / out_ready result handshake
//     sum, cout, ovf       result, carry out (no-borrow for sub), signed overflow
module dvsdclaa_pipe
  import dvsdclaa_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GRP   = DEF_GRP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = num_groups(WIDTH, GRP);
  localparam int LAST = NGRP - 1;
  localparam logic [WIDTH-1:0] GMASK = WIDTH'({GRP{1'b1}});

  if ((WIDTH % GRP) != 0 || WIDTH < GRP) begin : g_param_check
    $error("dvsdclaa_pipe: WIDTH must be a non-zero multiple of GRP");
  end

  // Stage inputs (what stage k computes on) and stage registers (what it holds).
  // Operand bits already consumed and sum bits not yet produced simply ride
  // along; their values are irrelevant.
  logic [WIDTH-1:0] a_in [NGRP];
  logic [WIDTH-1:0] b_in [NGRP];
  logic [WIDTH-1:0] s_in [NGRP];
  logic [WIDTH-1:0] s_nxt[NGRP];
  logic             c_in [NGRP];
  logic             c_nxt[NGRP];
  logic             v_in [NGRP];

  logic [WIDTH-1:0] a_q[NGRP];
  logic [WIDTH-1:0] b_q[NGRP];
  logic [WIDTH-1:0] s_q[NGRP];
  logic             c_q[NGRP];
  logic             v_q[NGRP];
  logic             ovf_q;
  logic             ovf_nxt;

  logic [GRP-1:0]   g_s [NGRP];
  logic             g_p [NGRP];
  logic             g_g [NGRP];
  logic             g_co[NGRP];
  logic             g_mc[NGRP];

  logic             adv;

  // A single advance signal moves the whole pipe; a stalled output freezes
  // every stage, which keeps the result stable and preserves order.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_in[k] = a;
      assign b_in[k] = sub ? ~b : b;
      assign c_in[k] = sub | cin;
      assign s_in[k] = '0;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    dvsdclaa_grp #(.GRP(GRP)) u_grp (
      .a       (a_in[k][k*GRP +: GRP]),
      .b       (b_in[k][k*GRP +: GRP]),
      .c       (c_in[k]),
      .s       (g_s[k]),
      .grp_p   (g_p[k]),
      .grp_g   (g_g[k]),
      .cout    (g_co[k]),
      .msb_cin (g_mc[k])
    );

    assign s_nxt[k] = (s_in[k] & ~(GMASK << (k*GRP))) | (WIDTH'(g_s[k]) << (k*GRP));

    if (k == LAST) begin : g_cout
      assign c_nxt[k] = g_co[k];
    end else begin : g_carry
      assign c_nxt[k] = g_g[k] | (g_p[k] & c_in[k]);
    end
  end

  assign ovf_nxt = g_co[LAST] ^ g_mc[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NGRP; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= c_nxt[k];
        s_q[k] <= s_nxt[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dvsdclaa_pipe.sv
// tb_dvsdclaa_pipe
//   Directed and random checks of the pipelined CLA: reset, carry/overflow
//   corners, backpressure, throughput, and smaller/larger parameter sets.
module tb_dvsdclaa_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main 16-bit instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  dvsdclaa_pipe #(.WIDTH(16), .GRP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // parameter-sweep instances, all fed from the same stimulus
  logic        sw_valid, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        sw_rdy[3], sw_ov[3], sw_co[3], sw_of[3];
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [31:0] sw_sum[3];
  assign sw_sum[0] = 32'(s4);
  assign sw_sum[1] = 32'(s8);
  assign sw_sum[2] = s32;

  dvsdclaa_pipe #(.WIDTH(4), .GRP(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
    .a(sw_a[3:0]), .b(sw_b[3:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[0]), .out_ready(1'b1),
    .sum(s4), .cout(sw_co[0]), .ovf(sw_of[0])
  );
  dvsdclaa_pipe #(.WIDTH(8), .GRP(4)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[1]), .out_ready(1'b1),
    .sum(s8), .cout(sw_co[1]), .ovf(sw_of[1])
  );
  dvsdclaa_pipe #(.WIDTH(32), .GRP(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_ov[2]), .out_ready(1'b1),
    .sum(s32), .cout(sw_co[2]), .ovf(sw_of[2])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: {ovf, cout, sum} for a w-bit add/sub.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] va, input logic [31:0] vb,
                                            input logic vc, input logic vs);
    logic [63:0] mask, aa, bb, full;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, va} & mask;
    bb   = (vs ? ~{32'd0, vb} : {32'd0, vb}) & mask;
    full = aa + bb + {63'd0, (vs | vc)};
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {ov, co, full[31:0] & mask[31:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // main scoreboard, sampled mid-cycle
  logic [33:0] exp_q[$];
  int          n_cons = 0;
  int          last_fire_cyc = 0;
  logic        held_v = 1'b0;
  logic [18:0] held;

  initial forever begin
    logic [33:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_stable", 64'({out_valid, ovf, cout, sum}), 64'(held));
      end
      held_v = out_valid && !out_ready;
      held   = {out_valid, ovf, cout, sum};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(sum), 64'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({ovf, cout, sum}), 64'({e[33:32], e[15:0]}));
        end
        n_cons++;
        last_fire_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(16, 32'(a), 32'(b), cin, sub));
      end
    end
  end

  // sweep scoreboard
  logic [33:0] sw_exp[3][128];
  int          sw_wp[3], sw_rp[3], sw_first_acc[3], sw_first_ov[3];
  int          sw_w[3]   = '{4, 8, 32};
  int          sw_lat[3] = '{1, 2, 4};

  initial begin
    for (int k = 0; k < 3; k++) begin
      sw_wp[k] = 0; sw_rp[k] = 0; sw_first_acc[k] = -1; sw_first_ov[k] = -1;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          if (sw_ov[k]) begin
            if (sw_rp[k] >= sw_wp[k]) begin
              check($sformatf("sw%0d_extra", sw_w[k]), 64'(sw_sum[k]), 64'hDEAD_BEEF);
            end else begin
              check($sformatf("sw%0d_result", sw_w[k]), 64'({sw_of[k], sw_co[k], sw_sum[k]}),
                    64'(sw_exp[k][sw_rp[k]]));
            end
            sw_rp[k]++;
            if (sw_first_ov[k] < 0) sw_first_ov[k] = cyc;
          end
          if (sw_valid && sw_rdy[k] && sw_wp[k] < 128) begin
            sw_exp[k][sw_wp[k]] = ref_model(sw_w[k], sw_a, sw_b, sw_cin, sw_sub);
            sw_wp[k]++;
            if (sw_first_acc[k] < 0) sw_first_acc[k] = cyc;
          end
        end
      end
    end
  end

  // Offer one beat; returns one cycle after the accepting edge (+#1).
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
    int n;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe; checks latency and the hand-computed result.
  task automatic vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic vc, input logic vs,
                     input logic [15:0] es, input logic ec, input logic eo);
    int n;
    send(va, vb, vc, vs);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"},  64'(n), 64'd4);
    check({tag, "_sum"},  64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"},  64'(ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int start, cons0, n;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum",       64'(sum),       64'd0);
    check("reset_cout",      64'(cout),      64'd0);
    check("reset_ovf",       64'(ovf),       64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);

    // corner vectors
    vec("carry_chain",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vec("ovf_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vec("sub_borrow",   16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    vec("add_cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    vec("grp_boundary", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
    vec("neg_ovf",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // reset with three beats in flight, first one already at the output
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0A0A, 16'h0505, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    check("pre_reset_sum",   64'(sum),       64'h3333);
    #1 rst = 1'b1;
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    check("mid_reset_sum",   64'(sum),       64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    vec("after_reset", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    check("after_reset_empty", 64'(exp_q.size()), 64'd0);

    // backpressure: 8 beats, 5 stalled cycles after the first result
    cons0 = n_cons;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_result", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready_full", 64'(in_ready),  64'd0);
        check("bp_out_held",      64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("bp_consumed", 64'(n_cons - cons0), 64'd8);
    check("bp_drained",  64'(exp_q.size()),   64'd0);

    // throughput: 100 back-to-back random beats
    start = cyc;
    cons0 = n_cons;
    for (int i = 0; i < 100; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    repeat (10) @(posedge clk);
    #1;
    check("tp_consumed", 64'(n_cons - cons0),        64'd100);
    check("tp_span",     64'(last_fire_cyc - start), 64'd103);

    // parameter sweep
    for (int i = 0; i < 64; i++) begin
      if (i == 0) begin
        sw_a = 32'hFFFF_FFFF; sw_b = 32'h1; sw_cin = 1'b0; sw_sub = 1'b0;
      end else if (i == 1) begin
        sw_a = 32'h8000_0080; sw_b = 32'h1; sw_cin = 1'b0; sw_sub = 1'b1;
      end else begin
        sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      end
      sw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sw%0d_count", sw_w[k]), 64'(sw_rp[k]), 64'd64);
      check($sformatf("sw%0d_latency", sw_w[k]), 64'(sw_first_ov[k] - sw_first_acc[k]), 64'(sw_lat[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
